// File: rtl/spi_burst_ctrl.sv
// SPI burst read controller: sends command + 16-bit flash address, then reads
// len+1 little-endian 16-bit words through a byte engine into local memory.
module spi_burst_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] faddr,
  input  logic [3:0]  len,
  input  logic [3:0]  base,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        ssn_out,
  output logic        spi_load,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        mem_we,
  output logic [3:0]  mem_addr,
  output logic [15:0] mem_wdata
);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADR_HI, ADR_LO, DATA_LO, DATA_HI, WRITE, CS_HOLD, FIN
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_opcode;
  logic [15:0] r_faddr;
  logic [3:0]  r_len;
  logic [3:0]  r_base;
  logic [3:0]  r_count;
  logic [15:0] r_wdata;
  logic        r_flight;
  logic        r_abort;

  logic w_is_byte, w_abort_req, w_byte_done, w_bail;

  assign w_is_byte   = r_state inside {CMD, ADR_HI, ADR_LO, DATA_LO, DATA_HI};
  assign w_abort_req = abort | r_abort;
  assign w_byte_done = w_is_byte & r_flight & spi_done;
  // Leave a byte state early only when no byte is outstanding on the engine.
  assign w_bail      = w_is_byte & w_abort_req & (~r_flight | spi_done);

  // NOTE: every signal driven here gets its default first, so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (start) w_state_nxt = CS_SETUP;
      CS_SETUP: w_state_nxt = abort ? CS_HOLD : CMD;
      CMD, ADR_HI, ADR_LO, DATA_LO, DATA_HI: begin
        if (w_bail) begin
          w_state_nxt = CS_HOLD;
        end else if (w_byte_done) begin
          case (r_state)
            CMD:     w_state_nxt = ADR_HI;
            ADR_HI:  w_state_nxt = ADR_LO;
            ADR_LO:  w_state_nxt = DATA_LO;
            DATA_LO: w_state_nxt = DATA_HI;
            default: w_state_nxt = WRITE;
          endcase
        end
      end
      WRITE:    w_state_nxt = (abort || r_count == r_len) ? CS_HOLD : DATA_LO;
      CS_HOLD:  w_state_nxt = FIN;
      FIN:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_tx = 8'h00;
    case (r_state)
      CMD:     spi_tx = r_opcode;
      ADR_HI:  spi_tx = r_faddr[15:8];
      ADR_LO:  spi_tx = r_faddr[7:0];
      default: spi_tx = 8'h00;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign ssn_out   = ~(r_state inside {CS_SETUP, CMD, ADR_HI, ADR_LO, DATA_LO,
                                       DATA_HI, WRITE, CS_HOLD});
  // An abort seen in a byte state's first cycle suppresses that byte's load.
  assign spi_load  = w_is_byte & ~r_flight & ~w_abort_req;
  assign mem_we    = (r_state == WRITE);
  assign mem_addr  = r_base + r_count;
  assign mem_wdata = r_wdata;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 8'h00;
      r_faddr  <= 16'h0000;
      r_len    <= 4'h0;
      r_base   <= 4'h0;
      r_count  <= 4'h0;
      r_wdata  <= 16'h0000;
      r_flight <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_opcode <= opcode;
        r_faddr  <= faddr;
        r_len    <= len;
        r_base   <= base;
        r_count  <= 4'h0;
      end

      if (r_state != w_state_nxt) r_flight <= 1'b0;
      else if (spi_load)          r_flight <= 1'b1;

      if (r_state != w_state_nxt)    r_abort <= 1'b0;
      else if (w_is_byte && abort)   r_abort <= 1'b1;

      if (w_byte_done && !w_abort_req) begin
        if (r_state == DATA_LO) r_wdata[7:0]  <= spi_rx;
        if (r_state == DATA_HI) r_wdata[15:8] <= spi_rx;
      end

      if (r_state == WRITE) r_count <= r_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl: a byte-engine model answers loads, the
// stimulus pushes expected bytes/writes/done cycles, a monitor pops and compares.
module tb_spi_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [15:0] faddr = 16'h0000;
  logic [3:0]  len = 4'h0;
  logic [3:0]  base = 4'h0;
  logic        abort = 1'b0;
  logic        busy, done, ssn_out, spi_load, mem_we;
  logic [7:0]  spi_tx;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rx = 8'h00;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;

  always #5 clk = ~clk;

  spi_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .faddr(faddr),
    .len(len), .base(base), .abort(abort), .busy(busy), .done(done),
    .ssn_out(ssn_out), .spi_load(spi_load), .spi_tx(spi_tx),
    .spi_done(spi_done), .spi_rx(spi_rx), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int load_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int ssn_low = 0;
  bit first_load = 1'b1;

  logic [7:0]  exp_tx[$];
  logic [19:0] exp_wr[$];
  int          exp_done[$];
  logic [7:0]  rx_q[$];

  int eng_n = 1;
  bit eng_extra = 1'b0;
  int spur_req = 0;
  int spur_ack = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-engine model: answers each load with spi_done eng_n cycles later.
  initial begin
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (eng_extra && mem_we) begin
        spi_done = 1'b1;
        spi_rx   = 8'hC3;
      end else if (spur_req != spur_ack) begin
        spur_ack++;
        spi_done = 1'b1;
        spi_rx   = 8'h3C;
      end
      if (spi_load === 1'b1 && rst_n === 1'b1) begin
        repeat (eng_n) @(negedge clk);
        spi_done = 1'b1;
        spi_rx   = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a load, write or done.
  initial begin
    logic [7:0]  et;
    logic [19:0] ew;
    int          ed;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        ssn_low = 0;
      end else begin
        if (!busy) first_load = 1'b1;
        if (spi_load) begin
          load_cnt++;
          if (first_load) begin
            check("cs_setup_cycles", ssn_low, 1);
            first_load = 1'b0;
          end
          check("tx_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) begin
            et = exp_tx.pop_front();
            check("spi_tx", spi_tx, et);
          end
          check("ssn_at_load", ssn_out, 0);
        end
        if (mem_we) begin
          wr_cnt++;
          check("write_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            ew = exp_wr.pop_front();
            check("mem_addr", mem_addr, ew[19:16]);
            check("mem_wdata", mem_wdata, ew[15:0]);
          end
          check("ssn_at_write", ssn_out, 0);
        end
        if (done) begin
          done_cnt++;
          check("done_expected", exp_done.size() != 0, 1);
          if (exp_done.size() != 0) begin
            ed = exp_done.pop_front();
            if (ed >= 0) check("done_cycle", cyc, ed);
          end
          check("fin_ssn_high", ssn_out, 1);
          check("fin_busy", busy, 1);
        end
        ssn_low = ssn_out ? 0 : ssn_low + 1;
      end
    end
  end

  task automatic issue(input logic [7:0] op, input logic [15:0] fa, input logic [3:0] l,
                       input logic [3:0] b, input int n, input int ld_words,
                       input int wr_words, input logic [7:0] lo0, input logic [7:0] hi0,
                       input bit timed, input bit with_abort);
    int lat;
    eng_n = n;
    exp_tx.push_back(op);
    exp_tx.push_back(fa[15:8]);
    exp_tx.push_back(fa[7:0]);
    for (int i = 0; i < 3; i++) rx_q.push_back(8'h5A);
    for (int i = 0; i < ld_words; i++) begin
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00);
      rx_q.push_back(8'(lo0 + i));
      rx_q.push_back(8'(hi0 + i));
    end
    for (int i = 0; i < wr_words; i++)
      exp_wr.push_back({4'(b + i), 8'(hi0 + i), 8'(lo0 + i)});
    lat = 1 + 3 * (n + 1) + (int'(l) + 1) * (2 * (n + 1) + 1) + 3;
    @(negedge clk);
    start = 1'b1; opcode = op; faddr = fa; len = l; base = b; abort = with_abort;
    exp_done.push_back(timed ? cyc + lat - 1 : -1);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    check("done_count", done_cnt, target);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, target);
  endtask

  task automatic wait_load(input int target);
    for (int i = 0; i < 3000 && load_cnt < target; i++) @(negedge clk);
    check("load_count", load_cnt, target);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ssn", ssn_out, 1);
    check("rst_load", spi_load, 0);
    check("rst_tx", spi_tx, 8'h00);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 4'h0);
    check("rst_wdata", mem_wdata, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, lc0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic single-word burst: tx 03,12,34,00,00; write 5 <= 55AA.
    issue(8'h03, 16'h1234, 4'h0, 4'h5, 2, 1, 1, 8'hAA, 8'h55, 1'b1, 1'b0);
    wait_done(1);

    // Spurious spi_done in IDLE: nothing happens.
    w0 = wr_cnt;
    spur_req++;
    repeat (3) @(negedge clk);
    check("idle_spur_busy", busy, 0);
    check("idle_spur_no_write", wr_cnt, w0);

    // Extra spi_done during every WRITE cycle is ignored.
    eng_extra = 1'b1;
    issue(8'hA5, 16'h00F0, 4'h2, 4'h3, 1, 3, 3, 8'h10, 8'h20, 1'b1, 1'b0);
    wait_done(2);
    eng_extra = 1'b0;

    // Full 16-word burst wrapping E,F,0..D.
    issue(8'h0B, 16'h4000, 4'hF, 4'hE, 1, 16, 16, 8'h00, 8'h80, 1'b1, 1'b0);
    wait_done(3);

    // Abort mid DATA_HI of word 2 (third word): only 2 writes.
    w0  = wr_cnt;
    lc0 = load_cnt;
    issue(8'h0B, 16'h0400, 4'h7, 4'h2, 3, 3, 2, 8'h31, 8'hC1, 1'b0, 1'b0);
    wait_load(lc0 + 9);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(4);
    check("abort_writes", wr_cnt, w0 + 2);

    // Abort together with start in IDLE: start wins, normal burst.
    issue(8'h9F, 16'h0007, 4'h0, 4'hF, 1, 1, 1, 8'h66, 8'h99, 1'b1, 1'b1);
    wait_done(5);

    // Start held every cycle with junk fields during a burst: ignored.
    issue(8'h5A, 16'h2468, 4'h1, 4'h8, 1, 2, 2, 8'h40, 8'h50, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      start = 1'b1; opcode = 8'hFF; faddr = 16'hDEAD; len = 4'hF; base = 4'h0;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(6);
    issue(8'h6B, 16'h1357, 4'h0, 4'h1, 2, 1, 1, 8'h0F, 8'hF0, 1'b1, 1'b0);
    wait_done(7);

    // Reset during ADR_LO: outputs return to reset values at once, no done/write.
    lc0 = load_cnt;
    issue(8'h3B, 16'h8001, 4'h1, 4'h9, 2, 2, 2, 8'h77, 8'h88, 1'b0, 1'b0);
    wait_load(lc0 + 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_tx.delete();
    exp_wr.delete();
    exp_done.delete();
    d0 = done_cnt;
    w0 = wr_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rx_q.delete();
    check("rst_no_done", done_cnt, d0);
    check("rst_no_write", wr_cnt, w0);

    // First burst after reset behaves as from power-up.
    issue(8'h03, 16'hABCD, 4'h0, 4'h0, 1, 1, 1, 8'h12, 8'h34, 1'b1, 1'b0);
    wait_done(d0 + 1);

    check("left_tx", exp_tx.size(), 0);
    check("left_wr", exp_wr.size(), 0);
    check("left_done", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
